// File: rtl/spi_shift_engine.sv
// SPI serial shift engine: turns PCLK-synchronous sclk edges into MOSI shifts and MISO samples.
// Optional internal loopback (mosi register -> sample path) enabled by defining SPI_LOOPBACK_EN.
module spi_shift_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  ss,
  input  logic                  send_data,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  lsbfe,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  miso,
`ifdef SPI_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  receive_data,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_sclk_d;
  logic                  r_lsbfe;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [CW-1:0]         r_bit_cnt;
  logic                  r_mosi;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_receive;
  logic                  r_busy;

  logic                  w_edge;
  logic                  w_lead;
  logic                  w_trail;
  logic                  w_xfer;
  logic                  w_load;
  logic                  w_sample;
  logic                  w_shift_edge;
  logic                  w_shift_en;
  logic                  w_done;
  logic                  w_abort;
  logic                  w_rx_bit;
  logic [DATA_WIDTH-1:0] w_rx_next;
  logic                  w_tx_bit;
  logic [DATA_WIDTH-1:0] w_tx_adv;
  logic                  w_ld_first;
  logic [DATA_WIDTH-1:0] w_ld_adv;

  assign w_edge       = (sclk != r_sclk_d);
  assign w_lead       = w_edge && (sclk != cpol);
  assign w_trail      = w_edge && (sclk == cpol);
  assign w_xfer       = (r_state == XFER);
  assign w_load       = (r_state == IDLE) && send_data && !ss;
  assign w_sample     = w_xfer && (cpha ? w_trail : w_lead);
  assign w_shift_edge = w_xfer && (cpha ? w_lead : w_trail);
  // cpha=0 already presented bit 0 at load, so its first shift waits for a sample
  assign w_shift_en   = w_shift_edge && (r_bit_cnt < CW'(DATA_WIDTH)) &&
                        (cpha || (r_bit_cnt != '0));
  assign w_done       = w_sample && (r_bit_cnt == CW'(DATA_WIDTH - 1));
  assign w_abort      = w_xfer && ss && !w_done;

`ifdef SPI_LOOPBACK_EN
  assign w_rx_bit = loopback ? r_mosi : miso;
`else
  assign w_rx_bit = miso;
`endif

  assign w_rx_next  = r_lsbfe ? {w_rx_bit, r_rx_shift[DATA_WIDTH-1:1]}
                              : {r_rx_shift[DATA_WIDTH-2:0], w_rx_bit};
  // r_tx_shift always holds the not-yet-driven bits, next one at the active end
  assign w_tx_bit   = r_lsbfe ? r_tx_shift[0] : r_tx_shift[DATA_WIDTH-1];
  assign w_tx_adv   = r_lsbfe ? (r_tx_shift >> 1) : (r_tx_shift << 1);
  assign w_ld_first = lsbfe ? tx_data[0] : tx_data[DATA_WIDTH-1];
  assign w_ld_adv   = lsbfe ? (tx_data >> 1) : (tx_data << 1);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_nxt = XFER;
      XFER:    if (w_done || ss) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sclk_d   <= 1'b0;
      r_lsbfe    <= 1'b0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_mosi     <= 1'b0;
      r_rx_data  <= '0;
      r_receive  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sclk_d  <= sclk;
      r_receive <= 1'b0;
      if (w_load) begin
        r_lsbfe    <= lsbfe;
        r_bit_cnt  <= '0;
        r_rx_shift <= '0;
        r_busy     <= 1'b1;
        if (!cpha) begin
          r_mosi     <= w_ld_first;
          r_tx_shift <= w_ld_adv;
        end else begin
          r_mosi     <= 1'b0;
          r_tx_shift <= tx_data;
        end
      end else if (w_done) begin
        r_rx_shift <= w_rx_next;
        r_bit_cnt  <= r_bit_cnt + CW'(1);
        r_rx_data  <= w_rx_next;
        r_receive  <= 1'b1;
        r_busy     <= 1'b0;
      end else if (w_abort) begin
        r_busy <= 1'b0;
        r_mosi <= 1'b0;
      end else begin
        if (w_sample) begin
          r_rx_shift <= w_rx_next;
          r_bit_cnt  <= r_bit_cnt + CW'(1);
        end
        if (w_shift_en) begin
          r_mosi     <= w_tx_bit;
          r_tx_shift <= w_tx_adv;
        end
      end
    end
  end

  assign mosi         = r_mosi;
  assign rx_data      = r_rx_data;
  assign receive_data = r_receive;
  assign busy         = r_busy;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: table-driven frames plus abort/busy/reset corner cases.
// Received frames are checked through an expected-value queue popped on each receive_data strobe.
module tb_spi_shift_engine;

  localparam int W = 8;

  logic         PCLK = 1'b0;
  logic         PRESETn = 1'b0;
  logic         ss = 1'b1;
  logic         send_data = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         lsbfe = 1'b0;
  logic         cpol = 1'b0;
  logic         cpha = 1'b0;
  logic         sclk = 1'b0;
  logic         miso = 1'b0;
  logic         loopback = 1'b0;
  logic         mosi;
  logic [W-1:0] rx_data;
  logic         receive_data;
  logic         busy;

  int           checks = 0;
  int           errors = 0;
  int           pulses = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_rx = '0;

  spi_shift_engine #(.DATA_WIDTH(W)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .ss          (ss),
    .send_data   (send_data),
    .tx_data     (tx_data),
    .lsbfe       (lsbfe),
    .cpol        (cpol),
    .cpha        (cpha),
    .sclk        (sclk),
    .miso        (miso),
`ifdef SPI_LOOPBACK_EN
    .loopback    (loopback),
`endif
    .mosi        (mosi),
    .rx_data     (rx_data),
    .receive_data(receive_data),
    .busy        (busy)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expected frame
  always @(negedge PCLK) begin
    if (PRESETn && receive_data) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: got 0x%0h with no frame expected at %0t", rx_data, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL rx_data: got 0x%0h expected 0x%0h at %0t", rx_data, e, $time);
        end
      end
      check("busy_at_strobe", 32'(busy), 32'd0);
    end
  end

  task automatic run_frame(input logic cp, input logic ch, input logic lf,
                           input logic [W-1:0] tx, input logic [W-1:0] mw,
                           input logic [W-1:0] exp_rx, input int abort_at,
                           input bit poke, input bit ss_end, input bit lb);
    int p0;
    logic eb;
    @(negedge PCLK);
    cpol = cp; cpha = ch; lsbfe = lf; sclk = cp; ss = 1'b0;
    tx_data = tx; miso = 1'b0; loopback = lb;
    repeat (3) @(negedge PCLK);
    p0 = pulses;
    send_data = 1'b1;
    @(negedge PCLK);
    send_data = 1'b0;
    check("busy_after_load", 32'(busy), 32'd1);
    if (ch) check("mosi_idle_cpha1", 32'(mosi), 32'd0);
    if (abort_at >= W) exp_q.push_back(exp_rx);
    eb = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (poke && i == 4) begin
        tx_data = 8'hFF; send_data = 1'b1;
        @(negedge PCLK);
        send_data = 1'b0;
      end
      if (i == abort_at) begin
        ss = 1'b1;
        @(negedge PCLK);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mosi", 32'(mosi), 32'd0);
        check("abort_rx_kept", 32'(rx_data), 32'(last_rx));
        repeat (3) @(negedge PCLK);
        check("abort_no_strobe", 32'(pulses), 32'(p0));
        return;
      end
      miso = lf ? mw[i] : mw[W-1-i];
      eb   = lf ? tx[i] : tx[W-1-i];
      if (!ch) check("mosi_bit_cpha0", 32'(mosi), 32'(eb));
      sclk = ~cp;
      if (!ch && ss_end && i == W-1) ss = 1'b1;
      repeat (2) @(negedge PCLK);
      if (ch) check("mosi_bit_cpha1", 32'(mosi), 32'(eb));
      sclk = cp;
      if (ch && ss_end && i == W-1) ss = 1'b1;
      repeat (2) @(negedge PCLK);
    end
    repeat (2) @(negedge PCLK);
    check("busy_after_frame", 32'(busy), 32'd0);
    check("single_strobe", 32'(pulses), 32'(p0 + 1));
    check("mosi_holds_last", 32'(mosi), 32'(eb));
    last_rx = exp_rx;
    ss = 1'b1;
  endtask

  typedef struct {
    logic         cp;
    logic         ch;
    logic         lf;
    logic [W-1:0] tx;
    logic [W-1:0] mw;
    logic [W-1:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{cp: 1'b0, ch: 1'b0, lf: 1'b0, tx: 8'hA5, mw: 8'h3C, exp_rx: 8'h3C};
    vecs[1] = '{cp: 1'b1, ch: 1'b1, lf: 1'b1, tx: 8'h81, mw: 8'h5A, exp_rx: 8'h5A};
    vecs[2] = '{cp: 1'b0, ch: 1'b1, lf: 1'b0, tx: 8'h6D, mw: 8'hB2, exp_rx: 8'hB2};
    vecs[3] = '{cp: 1'b1, ch: 1'b0, lf: 1'b1, tx: 8'h1E, mw: 8'hC9, exp_rx: 8'hC9};

    repeat (3) @(negedge PCLK);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_receive", 32'(receive_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    PRESETn = 1'b1;
    // Post-reset cpol mismatch produces an IDLE edge that must be ignored
    cpol = 1'b1; sclk = 1'b1;
    repeat (3) @(negedge PCLK);
    check("idle_edge_ignored", 32'(busy), 32'd0);

    foreach (vecs[k])
      run_frame(vecs[k].cp, vecs[k].ch, vecs[k].lf, vecs[k].tx, vecs[k].mw,
                vecs[k].exp_rx, W, 1'b0, 1'b0, 1'b0);

    run_frame(1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'h3C, W, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 8'hFF, 8'h99, 8'h00, 3, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 8'h00, 8'h96, 8'h96, W, 1'b1, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 8'h5B, 8'hE7, 8'hE7, W, 1'b0, 1'b1, 1'b0);
    run_frame(1'b1, 1'b1, 1'b0, 8'h34, 8'h2F, 8'h2F, W, 1'b0, 1'b1, 1'b0);
`ifdef SPI_LOOPBACK_EN
    run_frame(1'b0, 1'b0, 1'b0, 8'hC3, 8'h00, 8'hC3, W, 1'b0, 1'b0, 1'b1);
    run_frame(1'b0, 1'b1, 1'b1, 8'h3A, 8'h00, 8'h3A, W, 1'b0, 1'b0, 1'b1);
    loopback = 1'b0;
`endif

    // Asynchronous reset in the middle of an all-ones frame
    @(negedge PCLK);
    cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sclk = 1'b0; ss = 1'b0; tx_data = 8'hFF;
    repeat (3) @(negedge PCLK);
    send_data = 1'b1;
    @(negedge PCLK);
    send_data = 1'b0;
    for (int t = 0; t < 3; t++) begin
      sclk = ~sclk;
      repeat (2) @(negedge PCLK);
    end
    check("pre_reset_busy", 32'(busy), 32'd1);
    check("pre_reset_mosi", 32'(mosi), 32'd1);
    #3 PRESETn = 1'b0;
    #1;
    check("async_rst_mosi", 32'(mosi), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_rx", 32'(rx_data), 32'd0);
    check("async_rst_recv", 32'(receive_data), 32'd0);
    @(negedge PCLK);
    ss = 1'b1; sclk = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    last_rx = '0;
    run_frame(vecs[0].cp, vecs[0].ch, vecs[0].lf, vecs[0].tx, vecs[0].mw,
              vecs[0].exp_rx, W, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge PCLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Serial data path of the APB SPI core; sits directly downstream of the baud generator.
- Consumes the baud generator's PCLK-synchronous `sclk` and turns its edges into MOSI shift and MISO sample events.
- Serialises one `DATA_WIDTH` frame from the TX buffer and deserialises the received frame.
- Reports completion to the control/status logic with a one-cycle strobe.

Parameters:
- DATA_WIDTH, 8, frame length in bits (≥2); bit counter width is $clog2(DATA_WIDTH)+1.

Ports:
- PCLK  in  1  APB clock; all logic on its rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- ss  in  1  slave select, active low; high means no transfer allowed.
- send_data  in  1  one-cycle request to start a frame.
- tx_data  in  DATA_WIDTH  frame to transmit; latched when send_data is accepted.
- lsbfe  in  1  1 = LSB first, 0 = MSB first; sampled at load and held for the frame.
- cpol  in  1  clock idle level.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- sclk  in  1  serial clock from the baud generator, registered on PCLK.
- miso  in  1  serial data in.
- mosi  out  1  serial data out, registered.
- rx_data  out  DATA_WIDTH  last completed received frame.
- receive_data  out  1  one-cycle pulse when rx_data is updated.
- busy  out  1  high from load until frame completion or abort.

Behaviour:
- Reset values: mosi=0, rx_data=0, receive_data=0, busy=0, state=IDLE, sclk_d=0, counters=0, shift registers=0.
- Edge detect:
  - sclk_d <= sclk every cycle. An edge exists in a cycle when sclk != sclk_d.
  - Leading edge: sclk != cpol after the change. Trailing edge: sclk == cpol after the change.
  - Edges are acted on only in XFER. Edges in IDLE (including a post-reset cpol mismatch) are ignored.
- Sample edge is the leading edge when cpha=0 and the trailing edge when cpha=1. The shift edge is the other one.
- States: IDLE, XFER.
- IDLE -> XFER when send_data=1 and ss=0:
  - Load tx_shift<=tx_data, bit_cnt<=0, busy<=1, latch lsbfe.
  - If cpha=0, mosi <= first bit (tx_data[W-1] if MSB first, tx_data[0] if LSB first) in the same cycle.
  - If cpha=1, mosi holds 0 until the first shift edge.
- send_data with ss=1, or while busy, is ignored with no side effect.
- XFER, sample edge:
  - MSB first: rx_shift <= {rx_shift[W-2:0], miso}. LSB first: rx_shift <= {miso, rx_shift[W-1:1]}.
  - bit_cnt increments.
- XFER, shift edge:
  - Drive the next tx bit onto mosi (tx_shift shifts left if MSB first, right if LSB first).
  - cpha=0: shift only when 0 < bit_cnt < W, so no extra shift after the final sample.
  - cpha=1: shift on every shift edge while bit_cnt < W.
- Completion, when the sample edge makes bit_cnt reach W:
  - Next cycle: rx_data <= assembled frame (including the bit just sampled), receive_data=1 for exactly one cycle, busy=0, state=IDLE.
  - mosi holds its last value until the next load or abort.
- Abort: ss rising to 1 in XFER → next cycle state=IDLE, busy=0, mosi=0, rx_data unchanged, no receive_data.
- Simultaneous completion and ss rising in the same cycle: completion wins; receive_data still pulses.
- Asynchronous reset mid-frame returns all outputs to reset values immediately.
- Latency:
  - Edge seen in cycle N → mosi/rx_shift updated at the end of N.
  - Completion strobe in cycle N+1 after the final sample edge.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined:
  - Adds input port `loopback` (1 bit).
  - When loopback=1, the sampled bit is the internal mosi register instead of the miso pin.
  - The mosi pin still drives normally.
- Undefined: no `loopback` port; miso is always sampled.

Test Plan:
- cpol=0, cpha=0, lsbfe=0, sclk period 4 PCLK, tx_data=8'hA5, miso driving 8'h3C MSB first → mosi emits 1,0,1,0,0,1,0,1; receive_data pulses once; rx_data=8'h3C; busy low after.
- cpol=1, cpha=1, lsbfe=1, tx_data=8'h81, miso=8'h5A LSB first → mosi stays 0 until the first leading edge, then 1,0,0,0,0,0,0,1; rx_data=8'h5A.
- ss raised after 3 sample edges with rx_data previously 8'h3C → busy=0 and mosi=0 next cycle, no receive_data, rx_data remains 8'h3C.
- send_data pulsed while busy with tx_data=8'hFF during an 8'h00 frame → transmitted frame stays 8'h00; single receive_data pulse.
- Completion sample edge in the same cycle ss rises → receive_data pulses, rx_data updated.
- SPI_LOOPBACK_EN defined, loopback=1, tx_data=8'hC3, miso tied 0 → rx_data=8'hC3.
